// File: rtl/div_result_bcd_if.sv
// -----------------------------------------------------------------------------
// div_result_bcd_if
//
// Bundles the divider-result handshake between the long-division controller
// (master) and the BCD result stage (slave).
//
// Build option:
//   DIV_BCD_BLANK_EN - adds the q_blank / r_blank leading-zero blanking vectors.
//
// Signals:
//   done        master->slave  one-cycle divider completion pulse
//   error       master->slave  divide-by-zero flag, valid with done
//   quotient    master->slave  SIZE-bit unsigned quotient, valid with done
//   remainder   master->slave  SIZE-bit unsigned remainder, valid with done
//   busy        slave->master  conversion in progress
//   valid       slave->master  held outputs carry a completed result
//   new_result  slave->master  one-cycle pulse when a result is committed
//   err_out     slave->master  latched divider error of the held result
//   q_bcd       slave->master  quotient, packed BCD, digit 0 in [3:0]
//   r_bcd       slave->master  remainder, packed BCD, digit 0 in [3:0]
//   q_blank     slave->master  (DIV_BCD_BLANK_EN) quotient blanking mask
//   r_blank     slave->master  (DIV_BCD_BLANK_EN) remainder blanking mask
// -----------------------------------------------------------------------------
interface div_result_bcd_if #(
    parameter int SIZE   = 8,
    parameter int DIGITS = 3
);
    logic                  done;
    logic                  error;
    logic [SIZE-1:0]       quotient;
    logic [SIZE-1:0]       remainder;
    logic                  busy;
    logic                  valid;
    logic                  new_result;
    logic                  err_out;
    logic [4*DIGITS-1:0]   q_bcd;
    logic [4*DIGITS-1:0]   r_bcd;
`ifdef DIV_BCD_BLANK_EN
    logic [DIGITS-1:0]     q_blank;
    logic [DIGITS-1:0]     r_blank;

    modport master (
        output done, error, quotient, remainder,
        input  busy, valid, new_result, err_out, q_bcd, r_bcd, q_blank, r_blank
    );

    modport slave (
        input  done, error, quotient, remainder,
        output busy, valid, new_result, err_out, q_bcd, r_bcd, q_blank, r_blank
    );
`else
    modport master (
        output done, error, quotient, remainder,
        input  busy, valid, new_result, err_out, q_bcd, r_bcd
    );

    modport slave (
        input  done, error, quotient, remainder,
        output busy, valid, new_result, err_out, q_bcd, r_bcd
    );
`endif
endinterface

// File: rtl/div_result_bcd.sv
// -----------------------------------------------------------------------------
// div_result_bcd
//
// Result stage behind the long-division datapath. On the divider's done pulse
// it captures quotient, remainder and the error flag, converts quotient and
// then remainder to packed BCD with a serial double-dabble (one bit per clock),
// and commits the pair to registered outputs that stay stable for the
// seven-segment driver until the next division completes.
//
// A divide-by-zero skips conversion and commits zeros with err_out set.
// done pulses arriving while a conversion or commit is in flight are ignored.
//
// Build option:
//   DIV_BCD_BLANK_EN - also registers q_blank / r_blank leading-zero masks.
//
// Parameters:
//   SIZE    divider operand width (quotient / remainder bits)
//   DIGITS  BCD digits per value; 10**DIGITS must exceed 2**SIZE - 1
//           (must match the parameters of the connected interface)
//
// Ports:
//   clk     system clock, rising edge
//   reset   synchronous, active-high reset (aborts any conversion)
//   bus     div_result_bcd_if slave modport (see interface header)
// -----------------------------------------------------------------------------
module div_result_bcd #(
    parameter int SIZE   = 8,
    parameter int DIGITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    div_result_bcd_if.slave  bus
);

    localparam int BW = 4 * DIGITS;          // BCD accumulator width
    localparam int CW = $clog2(SIZE + 1);    // bit counter holds 0..SIZE

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CONV_Q = 2'd1;
    localparam logic [1:0] CONV_R = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]        state;
    logic [CW-1:0]     bit_cnt;
    logic [SIZE-1:0]   bin_sr;       // binary value being shifted out MSB first
    logic [SIZE-1:0]   rem_hold;     // remainder parked while quotient converts
    logic [BW-1:0]     bcd_acc;      // double-dabble BCD accumulator
    logic [BW-1:0]     q_pend;       // converted quotient awaiting commit
    logic [BW-1:0]     r_pend;       // converted remainder awaiting commit
    logic              err_pend;     // error flag awaiting commit

    logic              busy_r;
    logic              valid_r;
    logic              new_result_r;
    logic              err_out_r;
    logic [BW-1:0]     q_bcd_r;
    logic [BW-1:0]     r_bcd_r;
`ifdef DIV_BCD_BLANK_EN
    logic [DIGITS-1:0] q_blank_r;
    logic [DIGITS-1:0] r_blank_r;
`endif

    // -------------------------------------------------------------------------
    // Double-dabble step helpers
    // -------------------------------------------------------------------------

    // Correct every digit >= 5 by +3 so the following shift carries a
    // decimal overflow into the next digit.
    function automatic logic [BW-1:0] add3_digits(input logic [BW-1:0] v);
        logic [BW-1:0] res;
        res = v;
        for (int d = 0; d < DIGITS; d++) begin
            if (v[4*d +: 4] >= 4'd5) begin
                res[4*d +: 4] = v[4*d +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

`ifdef DIV_BCD_BLANK_EN
    // A digit is blanked when it and every more-significant digit are zero.
    // Digit 0 always shows, so a value of zero still displays a single 0.
    function automatic logic [DIGITS-1:0] blank_mask(input logic [BW-1:0] v);
        logic [DIGITS-1:0] mask;
        logic              upper_zero;
        mask       = '0;
        upper_zero = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            upper_zero = upper_zero & (v[4*d +: 4] == 4'd0);
            mask[d]    = upper_zero;
        end
        return mask;
    endfunction

    // On an error both displays show only digit 0 (which carries 0).
    localparam logic [DIGITS-1:0] ERR_BLANK = {{(DIGITS-1){1'b1}}, 1'b0};
`endif

    // Next accumulator / shift register values for one conversion cycle:
    // add-3 is applied combinationally to the registered accumulator, then
    // {bcd, bin} shifts left one bit in the same clock.
    logic [BW-1:0]   bcd_adj;
    logic [BW-1:0]   bcd_shift;
    logic [SIZE-1:0] bin_shift;
    logic [CW-1:0]   cnt_dec;
    logic            last_bit;

    // NOTE: every always_comb output gets a value on every path (here by
    // unconditional assignment), otherwise synthesis infers a latch.
    always_comb begin
        bcd_adj   = add3_digits(bcd_acc);
        bcd_shift = {bcd_adj[BW-2:0], bin_sr[SIZE-1]};
        bin_shift = bin_sr << 1;
        cnt_dec   = bit_cnt - CW'(1);
        last_bit  = (bit_cnt == CW'(1));   // counter reaches 0 after this shift
    end

    // -------------------------------------------------------------------------
    // Controller and datapath
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            bin_sr       <= '0;
            rem_hold     <= '0;
            bcd_acc      <= '0;
            q_pend       <= '0;
            r_pend       <= '0;
            err_pend     <= 1'b0;
            busy_r       <= 1'b0;
            valid_r      <= 1'b0;
            new_result_r <= 1'b0;
            err_out_r    <= 1'b0;
            q_bcd_r      <= '0;
            r_bcd_r      <= '0;
`ifdef DIV_BCD_BLANK_EN
            q_blank_r    <= '0;
            r_blank_r    <= '0;
`endif
        end else begin
            // new_result is a pulse; only FINISH raises it.
            new_result_r <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.done) begin
                        if (bus.error) begin
                            // Nothing to convert: commit zeros with the flag.
                            q_pend   <= '0;
                            r_pend   <= '0;
                            err_pend <= 1'b1;
                            state    <= FINISH;
                        end else begin
                            bin_sr   <= bus.quotient;
                            rem_hold <= bus.remainder;
                            bcd_acc  <= '0;
                            bit_cnt  <= CW'(SIZE);
                            err_pend <= 1'b0;
                            busy_r   <= 1'b1;
                            state    <= CONV_Q;
                        end
                    end
                end

                CONV_Q: begin
                    if (last_bit) begin
                        // Quotient done; restart the same engine on the remainder.
                        q_pend  <= bcd_shift;
                        bcd_acc <= '0;
                        bin_sr  <= rem_hold;
                        bit_cnt <= CW'(SIZE);
                        state   <= CONV_R;
                    end else begin
                        bcd_acc <= bcd_shift;
                        bin_sr  <= bin_shift;
                        bit_cnt <= cnt_dec;
                    end
                end

                CONV_R: begin
                    bcd_acc <= bcd_shift;
                    bin_sr  <= bin_shift;
                    bit_cnt <= cnt_dec;
                    if (last_bit) begin
                        r_pend <= bcd_shift;
                        busy_r <= 1'b0;
                        state  <= FINISH;
                    end
                end

                FINISH: begin
                    q_bcd_r      <= q_pend;
                    r_bcd_r      <= r_pend;
                    err_out_r    <= err_pend;
`ifdef DIV_BCD_BLANK_EN
                    q_blank_r    <= err_pend ? ERR_BLANK : blank_mask(q_pend);
                    r_blank_r    <= err_pend ? ERR_BLANK : blank_mask(r_pend);
`endif
                    valid_r      <= 1'b1;
                    new_result_r <= 1'b1;
                    state        <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all registered)
    // -------------------------------------------------------------------------
    assign bus.busy       = busy_r;
    assign bus.valid      = valid_r;
    assign bus.new_result = new_result_r;
    assign bus.err_out    = err_out_r;
    assign bus.q_bcd      = q_bcd_r;
    assign bus.r_bcd      = r_bcd_r;
`ifdef DIV_BCD_BLANK_EN
    assign bus.q_blank    = q_blank_r;
    assign bus.r_blank    = r_blank_r;
`endif

endmodule

// File: tb/tb_div_result_bcd.sv
// -----------------------------------------------------------------------------
// tb_div_result_bcd
//
// Directed self-checking bench for div_result_bcd (SIZE=8, DIGITS=3).
// Each division is launched with a one-cycle done pulse; the bench then
// watches a fixed window of cycles, recording when new_result fires, how
// many cycles busy is high and what the committed outputs are, and compares
// them with hand-computed values. Blanking checks are compiled in only when
// DIV_BCD_BLANK_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_div_result_bcd;

    localparam int SIZE   = 8;
    localparam int DIGITS = 3;
    localparam int WINDOW = 30;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    div_result_bcd_if #(.SIZE(SIZE), .DIGITS(DIGITS)) bus ();

    div_result_bcd #(.SIZE(SIZE), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Outputs expected to be held from the previous committed result.
    logic        held_valid;
    logic        held_err;
    logic [11:0] held_q;
    logic [11:0] held_r;

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one division and check the committed result.
    //   exp_lat   : edge (counting the done-sampling edge as 0) after which
    //               new_result is high
    //   exp_busy  : number of sampled cycles with busy high
    //   inject_at : if > 0, a spurious done is driven so it is sampled at
    //               edge inject_at+1; it must be ignored
    task automatic run_div(input string tag,
                           input logic [7:0] q, input logic [7:0] r, input logic e,
                           input logic [11:0] exp_q, input logic [11:0] exp_r,
                           input logic exp_err, input int exp_lat,
                           input int exp_busy, input int inject_at);
        int          first_pulse;
        int          pulses;
        int          busy_cycles;
        logic [11:0] got_q;
        logic [11:0] got_r;
        logic        got_err;
        first_pulse = -1;
        pulses      = 0;
        busy_cycles = 0;
        got_q       = 'x;
        got_r       = 'x;
        got_err     = 1'bx;

        bus.done      = 1'b1;
        bus.quotient  = q;
        bus.remainder = r;
        bus.error     = e;
        tick();                         // edge 0: done sampled
        bus.done      = 1'b0;
        bus.quotient  = '0;
        bus.remainder = '0;
        bus.error     = 1'b0;

        for (int k = 0; k <= WINDOW; k++) begin
            if (k > 0) tick();
            if (inject_at > 0 && k == inject_at) begin
                bus.done      = 1'b1;
                bus.quotient  = 8'd200;
                bus.remainder = 8'd1;
                bus.error     = 1'b1;
            end
            if (inject_at > 0 && k == inject_at + 1) begin
                bus.done  = 1'b0;
                bus.error = 1'b0;
            end
            if (bus.busy === 1'b1) busy_cycles++;
            if (k == exp_lat - 1) begin
                // One cycle before commit the old result is still on display.
                check({tag, " held q before commit"}, 32'(bus.q_bcd), 32'(held_q));
                check({tag, " held valid before commit"}, 32'(bus.valid), 32'(held_valid));
            end
            if (bus.new_result === 1'b1) begin
                pulses++;
                if (first_pulse < 0) begin
                    first_pulse = k;
                    got_q   = bus.q_bcd;
                    got_r   = bus.r_bcd;
                    got_err = bus.err_out;
                    check({tag, " valid at commit"}, 32'(bus.valid), 32'd1);
                end
            end
        end

        check({tag, " latency"},      32'(first_pulse), 32'(exp_lat));
        check({tag, " pulse count"},  32'(pulses),      32'd1);
        check({tag, " busy cycles"},  32'(busy_cycles), 32'(exp_busy));
        check({tag, " q_bcd"},        32'(got_q),       32'(exp_q));
        check({tag, " r_bcd"},        32'(got_r),       32'(exp_r));
        check({tag, " err_out"},      32'(got_err),     32'(exp_err));
        check({tag, " q_bcd held"},   32'(bus.q_bcd),   32'(exp_q));
        check({tag, " valid held"},   32'(bus.valid),   32'd1);

        held_valid = 1'b1;
        held_err   = exp_err;
        held_q     = exp_q;
        held_r     = exp_r;
    endtask

    // Safety net against a hung simulation.
    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int changes;

        reset         = 1'b1;
        bus.done      = 1'b0;
        bus.error     = 1'b0;
        bus.quotient  = '0;
        bus.remainder = '0;
        repeat (3) tick();

        check("reset busy",       32'(bus.busy),       32'd0);
        check("reset valid",      32'(bus.valid),      32'd0);
        check("reset new_result", 32'(bus.new_result), 32'd0);
        check("reset err_out",    32'(bus.err_out),    32'd0);
        check("reset q_bcd",      32'(bus.q_bcd),      32'd0);
        check("reset r_bcd",      32'(bus.r_bcd),      32'd0);
`ifdef DIV_BCD_BLANK_EN
        check("reset q_blank",    32'(bus.q_blank),    32'd0);
        check("reset r_blank",    32'(bus.r_blank),    32'd0);
`endif
        reset = 1'b0;
        tick();
        held_valid = 1'b0;
        held_err   = 1'b0;
        held_q     = '0;
        held_r     = '0;

        // 28 r 4
        run_div("q28", 8'd28, 8'd4, 1'b0, 12'h028, 12'h004, 1'b0, 17, 16, 0);

        // Full-scale quotient, then 50 idle cycles with nothing moving.
        run_div("q255", 8'd255, 8'd0, 1'b0, 12'h255, 12'h000, 1'b0, 17, 16, 0);
        changes = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.q_bcd !== 12'h255 || bus.r_bcd !== 12'h000 ||
                bus.valid !== 1'b1 || bus.err_out !== 1'b0 ||
                bus.new_result !== 1'b0 || bus.busy !== 1'b0) changes++;
        end
        check("q255 idle hold", 32'(changes), 32'd0);

        // Divide by zero: no conversion, commit on the edge after capture.
        run_div("err", 8'd12, 8'd3, 1'b1, 12'h000, 12'h000, 1'b1, 1, 0, 0);
        tick();
        check("err err_out hold", 32'(bus.err_out), 32'd1);
`ifdef DIV_BCD_BLANK_EN
        check("err q_blank", 32'(bus.q_blank), 32'(3'b110));
        check("err r_blank", 32'(bus.r_blank), 32'(3'b110));
`endif

        // A second done five cycles in must not disturb the conversion.
        run_div("q99", 8'd99, 8'd5, 1'b0, 12'h099, 12'h005, 1'b0, 17, 16, 5);

        // Zero converts to all-zero BCD.
        run_div("zero", 8'd0, 8'd0, 1'b0, 12'h000, 12'h000, 1'b0, 17, 16, 0);

        // 42 r 3 first, so the reset below has non-zero outputs to clear.
        run_div("q42", 8'd42, 8'd3, 1'b0, 12'h042, 12'h003, 1'b0, 17, 16, 0);

        // Reset in the middle of a conversion discards it.
        bus.done      = 1'b1;
        bus.quotient  = 8'd50;
        bus.remainder = 8'd3;
        tick();                          // edge 0
        bus.done      = 1'b0;
        repeat (8) tick();               // edge 8
        reset = 1'b1;
        tick();                          // edge 9: reset sampled
        check("abort busy",       32'(bus.busy),       32'd0);
        check("abort valid",      32'(bus.valid),      32'd0);
        check("abort new_result", 32'(bus.new_result), 32'd0);
        check("abort err_out",    32'(bus.err_out),    32'd0);
        check("abort q_bcd",      32'(bus.q_bcd),      32'd0);
        check("abort r_bcd",      32'(bus.r_bcd),      32'd0);
        reset = 1'b0;
        changes = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.new_result !== 1'b0) changes++;
        end
        check("abort stays idle", 32'(changes), 32'd0);
        held_valid = 1'b0;
        held_err   = 1'b0;
        held_q     = '0;
        held_r     = '0;

        run_div("q7", 8'd7, 8'd2, 1'b0, 12'h007, 12'h002, 1'b0, 17, 16, 0);

`ifdef DIV_BCD_BLANK_EN
        run_div("blank", 8'd5, 8'd40, 1'b0, 12'h005, 12'h040, 1'b0, 17, 16, 0);
        check("blank q_blank", 32'(bus.q_blank), 32'(3'b110));
        check("blank r_blank", 32'(bus.r_blank), 32'(3'b100));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
